// File: rtl/afifo_pkg.sv
// Shared definitions for the asynchronous FIFO pointer blocks.
// Gray helpers work on a 32-bit container; narrower pointers are zero-extended.
package afifo_pkg;

  localparam int ADDRSIZE_DEF = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = gray;
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter built as an MSB-first XOR prefix chain.
module gray2bin_conv #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  // running XOR from the MSB down yields each binary bit
  always_comb begin
    logic acc;
    acc   = 1'b0;
    bin_o = '0;
    for (int i = W - 1; i >= 0; i--) begin
      acc      = acc ^ gray_i[i];
      bin_o[i] = acc;
    end
  end

endmodule

// File: rtl/wptr_full.sv
// Write-domain pointer and full/almost-full/occupancy/overflow status for the async FIFO.
// Status is computed from the synchronized read pointer, so it can only be pessimistic.
module wptr_full
  import afifo_pkg::*;
#(
  parameter int ADDRSIZE     = ADDRSIZE_DEF,
  parameter int AFULL_THRESH = (1 << ADDRSIZE) - 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                wovf_clr,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wcount,
  output logic                wovf
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] THRESH = PW'(AFULL_THRESH);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] wcount_q, wcount_d;
  logic          wfull_q, wfull_d;
  logic          walmost_q, walmost_d;
  logic          wovf_q, wovf_d;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] full_pat_s;
  logic          wen_s;
  logic          drop_s;

  gray2bin_conv #(.W(PW)) u_rptr_conv (
    .gray_i (wq2_rptr),
    .bin_o  (rbin_s)
  );

  assign wen_s  = winc & ~wfull_q;
  assign drop_s = winc & wfull_q;
  // full when the next write pointer has lapped the read pointer by exactly one depth
  assign full_pat_s = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};

  always_comb begin
    wbin_d    = wbin_q + {{ADDRSIZE{1'b0}}, wen_s};
    wptr_d    = PW'(bin2gray(32'(wbin_d)));
    wcount_d  = wbin_d - rbin_s;
    wfull_d   = (wptr_d == full_pat_s);
    walmost_d = (wcount_d >= THRESH);
    // a dropped write outranks a same-cycle clear
    wovf_d    = drop_s | (wovf_q & ~wovf_clr);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q    <= '0;
      wptr_q    <= '0;
      wcount_q  <= '0;
      wfull_q   <= 1'b0;
      walmost_q <= 1'b0;
      wovf_q    <= 1'b0;
    end else begin
      wbin_q    <= wbin_d;
      wptr_q    <= wptr_d;
      wcount_q  <= wcount_d;
      wfull_q   <= wfull_d;
      walmost_q <= walmost_d;
      wovf_q    <= wovf_d;
    end
  end

  assign wen          = wen_s;
  assign waddr        = wbin_q[ADDRSIZE-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_q;
  assign wcount       = wcount_q;
  assign wovf         = wovf_q;

endmodule

// File: tb/tb_wptr_full.sv
// Scoreboard bench for wptr_full: directed scenarios plus random traffic against an occupancy model.
`timescale 1ns/1ps
module tb_wptr_full;

  logic       wclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic       winc = 1'b0;
  logic [4:0] wq2_rptr = 5'd0;
  logic       wovf_clr = 1'b0;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wcount;
  logic       wovf;

  wptr_full #(.ADDRSIZE(4), .AFULL_THRESH(14)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr),
    .wovf_clr(wovf_clr), .wen(wen), .waddr(waddr), .wptr(wptr),
    .wfull(wfull), .walmost_full(walmost_full), .wcount(wcount), .wovf(wovf)
  );

  always #5 wclk = ~wclk;

  typedef struct { logic wen; logic [3:0] waddr; } comb_t;
  typedef struct { logic [4:0] wptr; logic full; logic af; logic [4:0] cnt; logic ovf; logic [3:0] waddr; } reg_t;

  comb_t cq[$];
  reg_t  rq[$];
  int errors = 0;
  int checks = 0;

  // reference model: count of accepted writes and read position, both mod 32
  int m_wb = 0;
  int rb = 0;
  bit m_full = 1'b0;
  bit m_ovf = 1'b0;
  bit prev_ok = 1'b0;
  bit saw_wrap = 1'b0;
  logic [4:0] prev_wptr = 5'd0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int gray(int b);
    return (b ^ (b >> 1)) & 31;
  endfunction

  task automatic cycle();
    @(posedge wclk);
    #2;
  endtask

  task automatic drive(input bit inc, input bit clr, input int rbn);
    comb_t c;
    reg_t r;
    bit acc;
    int occ;
    rb = rbn & 31;
    winc = inc;
    wovf_clr = clr;
    wq2_rptr = 5'(gray(rb));
    acc = inc && !m_full;
    c.wen = acc;
    c.waddr = 4'(m_wb % 16);
    cq.push_back(c);
    m_wb = (m_wb + (acc ? 1 : 0)) % 32;
    occ = (m_wb - rb + 32) % 32;
    m_ovf = (inc && m_full) || (m_ovf && !clr);
    m_full = (occ == 16);
    r.wptr = 5'(gray(m_wb));
    r.full = m_full;
    r.af = (occ >= 14);
    r.cnt = 5'(occ);
    r.ovf = m_ovf;
    r.waddr = 4'(m_wb % 16);
    rq.push_back(r);
  endtask

  task automatic do_cycle(input bit inc, input bit clr, input int rbn);
    cycle();
    drive(inc, clr, rbn);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_wptr"}, wptr, 0);
    chk({tag, "_wfull"}, wfull, 0);
    chk({tag, "_afull"}, walmost_full, 0);
    chk({tag, "_wcount"}, wcount, 0);
    chk({tag, "_wovf"}, wovf, 0);
    chk({tag, "_waddr"}, waddr, 0);
    chk({tag, "_wen"}, wen, 32'(winc));
  endtask

  // asserts reset asynchronously with a write pending, then releases and writes immediately
  task automatic reset_and_write();
    cycle();
    winc = 1'b1;
    wovf_clr = 1'b0;
    wrst_n = 1'b0;
    prev_ok = 1'b0;
    #1;
    check_zero("rst_async");
    cycle();
    check_zero("rst_hold");
    wrst_n = 1'b1;
    m_wb = 0;
    m_full = 1'b0;
    m_ovf = 1'b0;
    drive(1'b1, 1'b0, 0);
  endtask

  initial begin : comb_mon
    comb_t c;
    forever begin
      @(negedge wclk);
      if (cq.size() > 0) begin
        c = cq.pop_front();
        chk("wen", wen, c.wen);
        chk("waddr_pre", waddr, c.waddr);
      end
    end
  end

  initial begin : reg_mon
    reg_t r;
    forever begin
      @(posedge wclk);
      #1;
      if (rq.size() > 0) begin
        r = rq.pop_front();
        chk("wptr", wptr, r.wptr);
        chk("wfull", wfull, r.full);
        chk("walmost_full", walmost_full, r.af);
        chk("wcount", wcount, r.cnt);
        chk("wovf", wovf, r.ovf);
        chk("waddr", waddr, r.waddr);
        if (prev_ok) begin
          chk("gray_step", 32'($countones(wptr ^ prev_wptr) <= 1), 1);
          if (prev_wptr == 5'b10000 && wptr == 5'b00000) saw_wrap = 1'b1;
        end
        prev_wptr = wptr;
        prev_ok = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    int occ;
    // fill from empty: 16 writes
    reset_and_write();
    for (int i = 0; i < 15; i++) do_cycle(1'b1, 1'b0, 0);
    // overflow behaviour while full
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 0);
    do_cycle(1'b0, 1'b1, 0);
    do_cycle(1'b0, 1'b0, 0);
    do_cycle(1'b1, 1'b0, 0);
    do_cycle(1'b1, 1'b1, 0);
    do_cycle(1'b0, 1'b1, 0);
    // one read frees one slot, one write refills
    do_cycle(1'b0, 1'b0, 1);
    do_cycle(1'b1, 1'b0, 1);
    do_cycle(1'b0, 1'b0, 1);
    // wrap with reader trailing by two
    do_cycle(1'b0, 1'b0, (m_wb - 2 + 32) % 32);
    for (int i = 0; i < 40; i++) begin
      do_cycle(1'b1, 1'b0, (m_wb - 1 + 32) % 32);
      do_cycle(1'b0, 1'b0, rb);
    end
    chk("wrap_seen", 32'(saw_wrap), 1);
    // reset mid-burst at occupancy 9
    reset_and_write();
    for (int i = 0; i < 8; i++) do_cycle(1'b1, 1'b0, 0);
    reset_and_write();
    // simultaneous write and read at occupancy 15
    for (int i = 0; i < 14; i++) do_cycle(1'b1, 1'b0, 0);
    do_cycle(1'b1, 1'b0, 1);
    do_cycle(1'b0, 1'b0, 1);
    // random traffic; reader never overtakes the writer
    for (int i = 0; i < 300; i++) begin
      occ = (m_wb - rb + 32) % 32;
      do_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
               rb + int'($urandom_range(0, occ)));
    end
    do_cycle(1'b0, 1'b0, rb);
    cycle();
    cycle();
    chk("queues_drained", 32'(cq.size() + rq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
